// File: rtl/bk_sequencer_if.sv
// Sector request/acknowledge bus between the backup-RAM sequencer and the host.
interface bk_sequencer_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
    modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);
endinterface

// File: rtl/bk_sequencer.sv
// Backup-RAM save/load sequencer: walks BLOCKS sectors of a save slot through
// the host sector interface, with ack timeout and abort on a new ROM download.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transfer; sd_lba holds the last sector used
// REQ   | sd_rd or sd_wr asserted, waiting for sd_ack rise (timed)
// XFER  | host moving the sector, waiting for sd_ack fall
module bk_sequencer #(
    parameter int BLOCKS = 64,
    parameter int TO_W   = 20
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           downloading,
    input  logic           img_mounted,
    input  logic [31:0]    img_size,
    input  logic           bk_load,
    input  logic           bk_save,
    input  logic [1:0]     slot,
    bk_sequencer_if.master bus,
    output logic           bk_ena,
    output logic           busy,
    output logic           loading,
    output logic           done,
    output logic           timeout
);
    localparam int LB = $clog2(BLOCKS);
    localparam logic [LB-1:0]   BLK_LAST = {LB{1'b1}};
    // abort fires on the edge where the counter steps onto all-ones
    localparam logic [TO_W-1:0] TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t          state;
    logic [TO_W-1:0] to_cnt;
    logic            ack_q, load_q, save_q, dl_q;
    logic            load_g, save_g;
    logic            load_edge, save_edge, ack_rise, ack_fall, dl_rise;

    assign load_g    = bk_load & bk_ena;
    assign save_g    = bk_save & bk_ena;
    assign load_edge = load_g & ~load_q;
    assign save_edge = save_g & ~save_q;
    assign ack_rise  = bus.sd_ack & ~ack_q;
    assign ack_fall  = ~bus.sd_ack & ack_q;
    assign dl_rise   = downloading & ~dl_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            to_cnt     <= '0;
            ack_q      <= 1'b0;
            load_q     <= 1'b0;
            save_q     <= 1'b0;
            dl_q       <= 1'b0;
            bus.sd_lba <= '0;
            bus.sd_rd  <= 1'b0;
            bus.sd_wr  <= 1'b0;
            bk_ena     <= 1'b0;
            busy       <= 1'b0;
            loading    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            ack_q   <= bus.sd_ack;
            load_q  <= load_g;
            save_q  <= save_g;
            dl_q    <= downloading;
            done    <= 1'b0;
            timeout <= 1'b0;

            // mount is written last so it overrides the download clear
            if (dl_rise)
                bk_ena <= 1'b0;
            if (downloading && img_mounted && (img_size != 32'd0))
                bk_ena <= 1'b1;

            if (dl_rise && busy) begin
                bus.sd_rd <= 1'b0;
                bus.sd_wr <= 1'b0;
                busy      <= 1'b0;
                loading   <= 1'b0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (load_edge || save_edge) begin
                            bus.sd_lba <= 32'(slot) << LB;
                            loading    <= load_edge;
                            bus.sd_rd  <= load_edge;
                            bus.sd_wr  <= ~load_edge;
                            busy       <= 1'b1;
                            to_cnt     <= '0;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (ack_rise) begin
                            bus.sd_rd <= 1'b0;
                            bus.sd_wr <= 1'b0;
                            state     <= XFER;
                        end else if (to_cnt == TO_LAST) begin
                            to_cnt    <= to_cnt + TO_W'(1);
                            bus.sd_rd <= 1'b0;
                            bus.sd_wr <= 1'b0;
                            busy      <= 1'b0;
                            timeout   <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                    XFER: begin
                        if (ack_fall) begin
                            if (bus.sd_lba[LB-1:0] == BLK_LAST) begin
                                done    <= 1'b1;
                                busy    <= 1'b0;
                                loading <= 1'b0;
                                state   <= IDLE;
                            end else begin
                                // only the sector bits count; slot bits stay put
                                bus.sd_lba[LB-1:0] <= bus.sd_lba[LB-1:0] + LB'(1);
                                bus.sd_rd          <= loading;
                                bus.sd_wr          <= ~loading;
                                to_cnt             <= '0;
                                state              <= REQ;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
